// File: rtl/tomasulo.sv
// Tomasulo core: in-order issue into RS/ROB, out-of-order ALU/MUL execute, single CDB, in-order commit.
// ALU 1 cycle, MUL MUL_LAT cycles; issue stalls on full ROB or no free RS; a CDB loser is held and retried.
module tomasulo #(
    parameter int ROB_DEPTH  = 8,
    parameter int N_ALU_RS   = 4,
    parameter int N_MUL_RS   = 2,
    parameter int MUL_LAT    = 3,
    parameter int IMEM_DEPTH = 16,
    parameter int PROG       = 0
) (
    input logic clk,
    input logic reset
);
    localparam int TW  = $clog2(ROB_DEPTH);
    localparam int CW  = $clog2(ROB_DEPTH + 1);
    localparam int NRS = N_ALU_RS + N_MUL_RS;

    typedef struct packed {
        logic          busy, disp, wj, wk;
        logic [2:0]    op;
        logic [TW-1:0] tag, qj, qk;
        logic [31:0]   vj, vk;
    } rs_t;

    logic [31:0]   regs [0:31];
    logic [3:0]    pc;
    logic          halted;
    logic [7:0]    commit_count;
    logic [TW-1:0] rob_head, rob_tail;
    logic [CW-1:0] rob_count;
    logic          rob_vld [ROB_DEPTH];
    logic          rob_rdy [ROB_DEPTH];
    logic [4:0]    rob_rd  [ROB_DEPTH];
    logic [31:0]   rob_val [ROB_DEPTH];
    logic          rat_vld [32];
    logic [TW-1:0] rat_tag [32];
    rs_t           rs [NRS];
    logic          alu_vld;
    logic [TW-1:0] alu_tag;
    logic [31:0]   alu_val;
    logic          mv   [MUL_LAT];
    logic [TW-1:0] mt   [MUL_LAT];
    logic [31:0]   mval [MUL_LAT];
    logic          cdb_vld, alu_bcast;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_val;

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [11:0] imm);
        return {op, rd, r1, r2, 2'b00, imm};
    endfunction

    logic [31:0] inst;
    always_comb begin
        inst = '0;
        if (int'(pc) < IMEM_DEPTH) begin
            case (PROG)
                1: begin
                    // two chained MULs hold the ROB head so the ADDIs behind them fill the ROB
                    if (pc == 4'd0)       inst = enc(3'd6, 5'd11, 5'd0, 5'd0, 12'd0);
                    else if (pc == 4'd1)  inst = enc(3'd6, 5'd12, 5'd11, 5'd11, 12'd0);
                    else if (pc <= 4'd11) inst = enc(3'd3, {1'b0, pc} - 5'd1, 5'd0, 5'd0, {8'd0, pc} - 12'd1);
                    else if (pc == 4'd12) inst = enc(3'd7, 5'd0, 5'd0, 5'd0, 12'd0);
                end
                2: case (pc)
                    4'd0: inst = enc(3'd3, 5'd1, 5'd0, 5'd0, 12'd3);
                    4'd1: inst = enc(3'd6, 5'd2, 5'd1, 5'd1, 12'd0);
                    4'd4: inst = enc(3'd3, 5'd3, 5'd0, 5'd0, 12'hFFE);
                    4'd5: inst = enc(3'd7, 5'd0, 5'd0, 5'd0, 12'd0);
                    default: ;
                endcase
                default: case (pc)
                    4'd0: inst = enc(3'd3, 5'd1, 5'd0, 5'd0, 12'd5);
                    4'd1: inst = enc(3'd3, 5'd2, 5'd0, 5'd0, 12'd7);
                    4'd2: inst = enc(3'd1, 5'd3, 5'd1, 5'd2, 12'd0);
                    4'd3: inst = enc(3'd6, 5'd4, 5'd3, 5'd2, 12'd0);
                    4'd4: inst = enc(3'd2, 5'd5, 5'd4, 5'd1, 12'd0);
                    4'd5: inst = enc(3'd1, 5'd1, 5'd5, 5'd0, 12'd0);
                    4'd6: inst = enc(3'd7, 5'd0, 5'd0, 5'd0, 12'd0);
                    default: ;
                endcase
            endcase
        end
    end

    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        is_mul, is_alu, is_ctl, unused_ok;
    assign op        = inst[31:29];
    assign rd        = inst[28:24];
    assign rs1       = inst[23:19];
    assign rs2       = inst[18:14];
    assign imm       = {{20{inst[11]}}, inst[11:0]};
    assign unused_ok = &{1'b0, inst[13:12]};
    assign is_mul    = (op == 3'd6);
    assign is_alu    = (op != 3'd0) && (op < 3'd6);
    assign is_ctl    = !is_mul && !is_alu;

    // Operand source priority: regfile, ready ROB entry, same-cycle CDB, else wait on tag
    logic [4:0]    sreg [2];
    logic [31:0]   sval [2];
    logic          srdy [2];
    logic [TW-1:0] sq   [2];
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            sreg[s] = (s == 0) ? rs1 : rs2;
            sval[s] = regs[sreg[s]];
            srdy[s] = 1'b1;
            sq[s]   = rat_tag[sreg[s]];
            if (sreg[s] != 5'd0 && rat_vld[sreg[s]]) begin
                if (rob_rdy[sq[s]])                      sval[s] = rob_val[sq[s]];
                else if (cdb_vld && cdb_tag == sq[s])    sval[s] = cdb_val;
                else begin
                    srdy[s] = 1'b0;
                    sval[s] = '0;
                end
            end
        end
    end

    logic alu_free_ok, mul_free_ok;
    int   alu_free, mul_free;
    always_comb begin
        alu_free_ok = 1'b0; mul_free_ok = 1'b0; alu_free = 0; mul_free = 0;
        for (int i = NRS - 1; i >= 0; i--) begin
            if (!rs[i].busy) begin
                if (i < N_ALU_RS) begin alu_free_ok = 1'b1; alu_free = i; end
                else              begin mul_free_ok = 1'b1; mul_free = i; end
            end
        end
    end

    // Oldest-first: age is the distance of the RS's ROB tag from the head
    logic          alu_found, mul_found, alu_go, mul_go;
    int            alu_sel, mul_sel;
    logic [TW-1:0] age, alu_age, mul_age;
    always_comb begin
        alu_found = 1'b0; mul_found = 1'b0; alu_sel = 0; mul_sel = 0;
        alu_age = '1; mul_age = '1; age = '0;
        for (int i = 0; i < NRS; i++) begin
            if (rs[i].busy && !rs[i].disp && !rs[i].wj && !rs[i].wk) begin
                age = rs[i].tag - rob_head;
                if (i < N_ALU_RS) begin
                    if (!alu_found || age < alu_age) begin alu_found = 1'b1; alu_sel = i; alu_age = age; end
                end else begin
                    if (!mul_found || age < mul_age) begin mul_found = 1'b1; mul_sel = i; mul_age = age; end
                end
            end
        end
    end

    assign alu_bcast = alu_vld && !mv[MUL_LAT-1];
    assign alu_go    = alu_found && (!alu_vld || alu_bcast);
    assign mul_go    = mul_found;
    assign cdb_vld   = mv[MUL_LAT-1] || alu_vld;
    assign cdb_tag   = mv[MUL_LAT-1] ? mt[MUL_LAT-1] : alu_tag;
    assign cdb_val   = mv[MUL_LAT-1] ? mval[MUL_LAT-1] : alu_val;

    logic [31:0] alu_res, mul_res;
    always_comb begin
        case (rs[alu_sel].op)
            3'd1, 3'd3: alu_res = rs[alu_sel].vj + rs[alu_sel].vk;
            3'd2:       alu_res = rs[alu_sel].vj - rs[alu_sel].vk;
            3'd4:       alu_res = rs[alu_sel].vj & rs[alu_sel].vk;
            3'd5:       alu_res = rs[alu_sel].vj | rs[alu_sel].vk;
            default:    alu_res = '0;
        endcase
        mul_res = rs[mul_sel].vj * rs[mul_sel].vk;
    end

    logic do_issue, do_commit;
    rs_t  new_rs;
    assign do_issue  = !halted && (rob_count != CW'(ROB_DEPTH)) &&
                       (is_ctl || (is_alu && alu_free_ok) || (is_mul && mul_free_ok));
    assign do_commit = rob_vld[rob_head] && rob_rdy[rob_head];
    always_comb begin
        new_rs      = '0;
        new_rs.busy = 1'b1;
        new_rs.op   = op;
        new_rs.tag  = rob_tail;
        new_rs.wj   = !srdy[0];
        new_rs.qj   = sq[0];
        new_rs.vj   = sval[0];
        new_rs.wk   = (op == 3'd3) ? 1'b0 : !srdy[1];
        new_rs.qk   = sq[1];
        new_rs.vk   = (op == 3'd3) ? imm : sval[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0; halted <= 1'b0; commit_count <= '0;
            rob_head <= '0; rob_tail <= '0; rob_count <= '0;
            alu_vld <= 1'b0; alu_tag <= '0; alu_val <= '0;
            for (int i = 0; i < 32; i++) begin regs[i] <= '0; rat_vld[i] <= 1'b0; rat_tag[i] <= '0; end
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_vld[i] <= 1'b0; rob_rdy[i] <= 1'b0; rob_rd[i] <= '0; rob_val[i] <= '0;
            end
            for (int i = 0; i < NRS; i++) rs[i] <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin mv[s] <= 1'b0; mt[s] <= '0; mval[s] <= '0; end
        end else begin
            if (cdb_vld) begin
                rob_val[cdb_tag] <= cdb_val;
                rob_rdy[cdb_tag] <= 1'b1;
                for (int i = 0; i < NRS; i++) begin
                    if (rs[i].busy && rs[i].wj && rs[i].qj == cdb_tag) begin rs[i].vj <= cdb_val; rs[i].wj <= 1'b0; end
                    if (rs[i].busy && rs[i].wk && rs[i].qk == cdb_tag) begin rs[i].vk <= cdb_val; rs[i].wk <= 1'b0; end
                    if (rs[i].busy && rs[i].disp && rs[i].tag == cdb_tag) rs[i].busy <= 1'b0;
                end
            end
            if (alu_go) begin
                rs[alu_sel].disp <= 1'b1;
                alu_vld <= 1'b1; alu_tag <= rs[alu_sel].tag; alu_val <= alu_res;
            end else if (alu_bcast) begin
                alu_vld <= 1'b0;
            end
            if (mul_go) rs[mul_sel].disp <= 1'b1;
            mv[0] <= mul_go; mt[0] <= rs[mul_sel].tag; mval[0] <= mul_res;
            for (int s = 1; s < MUL_LAT; s++) begin mv[s] <= mv[s-1]; mt[s] <= mt[s-1]; mval[s] <= mval[s-1]; end
            if (do_commit) begin
                if (rob_rd[rob_head] != 5'd0) regs[rob_rd[rob_head]] <= rob_val[rob_head];
                if (rat_vld[rob_rd[rob_head]] && rat_tag[rob_rd[rob_head]] == rob_head)
                    rat_vld[rob_rd[rob_head]] <= 1'b0;
                rob_vld[rob_head] <= 1'b0;
                rob_head <= rob_head + TW'(1);
                commit_count <= commit_count + 8'd1;
            end
            // Issue comes after commit so a new rename of rd wins over the commit-time clear
            if (do_issue) begin
                rob_vld[rob_tail] <= 1'b1;
                rob_rdy[rob_tail] <= is_ctl;
                rob_rd[rob_tail]  <= is_ctl ? 5'd0 : rd;
                rob_val[rob_tail] <= '0;
                if (!is_ctl && rd != 5'd0) begin rat_vld[rd] <= 1'b1; rat_tag[rd] <= rob_tail; end
                if (is_alu)      rs[alu_free] <= new_rs;
                else if (is_mul) rs[mul_free] <= new_rs;
                rob_tail <= rob_tail + TW'(1);
                pc <= pc + 4'd1;
                if (op == 3'd7) halted <= 1'b1;
            end
            rob_count <= rob_count + CW'(do_issue) - CW'(do_commit);
        end
    end
endmodule

// File: tb/tb_tomasulo.sv
// Directed bench: default program, a ROB-filling program and a CDB-collision program run side by side.
module tb_tomasulo;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    tomasulo              dut  (.clk(clk), .reset(rst0));
    tomasulo #(.PROG(1))  dut1 (.clk(clk), .reset(rst1));
    tomasulo #(.PROG(2))  dut2 (.clk(clk), .reset(rst1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, 32'(dut.pc), 0);
        check({tag, "_halted"}, 32'(dut.halted), 0);
        check({tag, "_commit_count"}, 32'(dut.commit_count), 0);
        check({tag, "_rob_count"}, 32'(dut.rob_count), 0);
        check({tag, "_rob_head"}, 32'(dut.rob_head), 0);
        check({tag, "_rob_tail"}, 32'(dut.rob_tail), 0);
        check({tag, "_r1"}, dut.regs[1], 0);
        check({tag, "_r3"}, dut.regs[3], 0);
    endtask

    task automatic check_final(input string tag);
        check({tag, "_r1"}, dut.regs[1], 79);
        check({tag, "_r2"}, dut.regs[2], 7);
        check({tag, "_r3"}, dut.regs[3], 12);
        check({tag, "_r4"}, dut.regs[4], 84);
        check({tag, "_r5"}, dut.regs[5], 79);
        check({tag, "_r6"}, dut.regs[6], 0);
        check({tag, "_r31"}, dut.regs[31], 0);
        check({tag, "_commit_count"}, 32'(dut.commit_count), 7);
        check({tag, "_halted"}, 32'(dut.halted), 1);
        check({tag, "_rob_count"}, 32'(dut.rob_count), 0);
    endtask

    initial begin
        int         mul_t;
        int         coll_t;
        int         stalls;
        bit         add_done, sub_done, raw_done, order_bad;
        logic [3:0] prev_pc;
        mul_t = -1; coll_t = -1; stalls = 0;
        add_done = 0; sub_done = 0; raw_done = 0; order_bad = 0;

        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        check_reset("reset");
        prev_pc = dut1.pc;

        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (!add_done && dut.pc == 4'd2) begin
                add_done = 1;
                check("add_r1_from_cdb", dut.sval[0], 5);
                check("add_r2_waits_tag", 32'(dut.srdy[1]), 0);
            end
            if (!sub_done && dut.pc == 4'd4) begin
                sub_done = 1;
                check("sub_reads_old_r1", dut.sval[1], 5);
            end
            if (mul_t < 0 && dut.mul_go) mul_t = cyc;
            if (mul_t >= 0 && cyc == mul_t + 3) begin
                check("mul_cdb_vld", 32'(dut.cdb_vld), 1);
                check("mul_cdb_tag", 32'(dut.cdb_tag), 3);
                check("mul_cdb_val", dut.cdb_val, 84);
            end
            if (!raw_done && dut.commit_count == 8'd3) begin
                raw_done = 1;
                check("r3_before_r4", dut.regs[3], 12);
                check("r4_not_committed", dut.regs[4], 0);
            end
            if (coll_t < 0 && dut2.cdb_vld && dut2.cdb_tag == 3'd1) begin
                coll_t = cyc;
                check("coll_mul_val", dut2.cdb_val, 9);
                check("coll_alu_held", 32'(dut2.alu_vld), 1);
            end
            if (coll_t >= 0 && cyc == coll_t + 1) begin
                check("coll_alu_tag", 32'(dut2.cdb_tag), 4);
                check("coll_alu_val", dut2.cdb_val, 32'hFFFF_FFFE);
            end
            if (!dut1.halted && dut1.pc == prev_pc) stalls++;
            prev_pc = dut1.pc;
            for (int k = 2; k <= 10; k++)
                if (dut1.regs[k] == 32'(k) && dut1.regs[k-1] != 32'(k - 1)) order_bad = 1;
        end

        check("add_issue_seen", 32'(add_done), 1);
        check("mul_dispatch_seen", 32'(mul_t >= 0), 1);
        check("raw_point_seen", 32'(raw_done), 1);
        check("collision_seen", 32'(coll_t >= 0), 1);
        check_final("run1");

        for (int k = 1; k <= 10; k++) check($sformatf("addi_r%0d", k), dut1.regs[k], 32'(k));
        check("addi_commit_count", 32'(dut1.commit_count), 13);
        check("addi_halted", 32'(dut1.halted), 1);
        check("addi_rob_count", 32'(dut1.rob_count), 0);
        check("addi_stall_seen", 32'(stalls > 0), 1);
        check("addi_in_order", 32'(order_bad), 0);

        check("coll_r1", dut2.regs[1], 3);
        check("coll_r2", dut2.regs[2], 9);
        check("coll_r3", dut2.regs[3], 32'hFFFF_FFFE);
        check("coll_commit_count", 32'(dut2.commit_count), 6);

        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_inflight", 32'(dut.rob_count != 0), 1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check_reset("reset_mid");
        repeat (30) @(negedge clk);
        check_final("rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
